cla_16bit_addsub: RTL and testbench

- 16-bit two's-complement adder/subtractor built on carry-lookahead logic, for the Execute-stage ALU.
- Computes A+B or A-B with wrap-around (non-saturating) and flags signed overflow on Error.
- Result and flag are registered once on the single clock.

---
 rtl/cla_16bit_addsub.sv | 101 ++++++++++
 tb/tb_cla_16bit_addsub.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cla_16bit_addsub.sv
// 16-bit two's-complement adder/subtractor for the Execute-stage ALU.
// Two-level carry-lookahead datapath; Sum and Error are registered once.
module cla_16bit_addsub (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        sub,
    output logic [15:0] Sum,
    output logic        Error
);

    // Group generate/propagate of a 4-bit slice, packed as {gg, pg}.
    function automatic logic [1:0] cla4_group_f(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] g;
        logic [3:0] p;
        logic       gg;
        logic       pg;
        g  = a & b;
        p  = a ^ b;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg = p[3] & p[2] & p[1] & p[0];
        return {gg, pg};
    endfunction

    // Sum bits of a 4-bit slice, internal carries from lookahead equations.
    function automatic logic [3:0] cla4_sum_f(input logic [3:0] a, input logic [3:0] b,
                                              input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return p ^ c;
    endfunction

    logic [15:0] beff_s;
    logic        cin_s;
    logic [3:0]  gg_s;
    logic [3:0]  pg_s;
    logic        c4_s;
    logic        c8_s;
    logic        c12_s;
    logic [15:0] raw_s;
    logic        ovf_s;
    logic [15:0] sum_r;
    logic        error_r;

    // Operand conditioning: subtraction is A + ~B + 1.
    always_comb begin
        beff_s = B;
        cin_s  = 1'b0;
        if (sub) begin
            beff_s = ~B;
            cin_s  = 1'b1;
        end else begin
            beff_s = B;
            cin_s  = 1'b0;
        end
    end

    // Slice group signals and second-level lookahead for slice carry-ins.
    always_comb begin
        {gg_s[0], pg_s[0]} = cla4_group_f(A[3:0],   beff_s[3:0]);
        {gg_s[1], pg_s[1]} = cla4_group_f(A[7:4],   beff_s[7:4]);
        {gg_s[2], pg_s[2]} = cla4_group_f(A[11:8],  beff_s[11:8]);
        {gg_s[3], pg_s[3]} = cla4_group_f(A[15:12], beff_s[15:12]);
        c4_s  = gg_s[0] | (pg_s[0] & cin_s);
        c8_s  = gg_s[1] | (pg_s[1] & gg_s[0]) | (pg_s[1] & pg_s[0] & cin_s);
        c12_s = gg_s[2] | (pg_s[2] & gg_s[1]) | (pg_s[2] & pg_s[1] & gg_s[0])
              | (pg_s[2] & pg_s[1] & pg_s[0] & cin_s);
    end

    // Result assembly and signed-overflow detection.
    always_comb begin
        raw_s[3:0]   = cla4_sum_f(A[3:0],   beff_s[3:0],   cin_s);
        raw_s[7:4]   = cla4_sum_f(A[7:4],   beff_s[7:4],   c4_s);
        raw_s[11:8]  = cla4_sum_f(A[11:8],  beff_s[11:8],  c8_s);
        raw_s[15:12] = cla4_sum_f(A[15:12], beff_s[15:12], c12_s);
        ovf_s = (A[15] == beff_s[15]) && (raw_s[15] != A[15]);
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r   <= 16'h0000;
            error_r <= 1'b0;
        end else begin
            sum_r   <= raw_s;
            error_r <= ovf_s;
        end
    end

    assign Sum   = sum_r;
    assign Error = error_r;

endmodule

// File: tb/tb_cla_16bit_addsub.sv
// Self-checking bench for cla_16bit_addsub: integer reference model checked
// every cycle, plus hand-computed literal vectors.
module tb_cla_16bit_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        sub;
    logic [15:0] Sum;
    logic        Error;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_sum;
    logic        exp_err;
    logic        exp_valid = 1'b0;

    cla_16bit_addsub dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .sub  (sub),
        .Sum  (Sum),
        .Error(Error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act_s, input logic [15:0] req_s,
                         input logic act_e, input logic req_e);
        checks++;
        if (act_s !== req_s || act_e !== req_e) begin
            errors++;
            $display("FAIL %s: got Sum=%h Error=%b, required Sum=%h Error=%b",
                     name, act_s, act_e, req_s, req_e);
        end
    endtask

    // Reference model: true signed integer arithmetic, then wrap and range test.
    always @(posedge clk) begin
        int r;
        if (!rst_n) begin
            exp_sum = 16'h0000;
            exp_err = 1'b0;
        end else begin
            if (sub) r = int'($signed(A)) - int'($signed(B));
            else     r = int'($signed(A)) + int'($signed(B));
            exp_sum = r[15:0];
            exp_err = (r > 32767) || (r < -32768);
        end
        exp_valid = 1'b1;
    end

    // Compare process, sampling away from the active edge.
    always @(negedge clk) begin
        if (exp_valid) check("model", Sum, exp_sum, Error, exp_err);
    end

    task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] req_s, input logic req_e);
        A = a; B = b; sub = s;
        @(posedge clk);
        @(negedge clk);
        check(name, Sum, req_s, Error, req_e);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        rst_n = 1'b0;
        A = 16'h1234; B = 16'h1111; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset", Sum, 16'h0000, Error, 1'b0);
        rst_n = 1'b1;
        apply("reset_release", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);

        apply("zero",        16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        apply("add_ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
        apply("add_ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1);
        apply("sub_neg",     16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
        apply("sub_ovf_neg", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1);
        apply("sub_ovf_pos", 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1);
        apply("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
        apply("a_minus_a",   16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0);
        apply("zero_minus_min", 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1);
        apply("nibble_carry", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);

        // Reset mid-stream takes priority over the operation presented.
        rst_n = 1'b0;
        apply("reset_priority", 16'h7FFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
        rst_n = 1'b1;

        // Back-to-back: new vector every cycle, alternating sub; model checks each.
        for (int i = 0; i < 32; i++) begin
            A = 16'(i * 16'h0911); B = 16'(16'hF00F - i * 16'h0123); sub = i[0];
            @(negedge clk);
        end

        // A - A is zero for any A.
        for (int i = 0; i < 64; i++) begin
            ra = 16'($urandom);
            A = ra; B = ra; sub = 1'b1;
            @(negedge clk);
        end

        // Random regression: 512 vectors per sub value, some biased to extremes.
        for (int i = 0; i < 1024; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = {ra[0], {15{~ra[0]}}};
            if ($urandom_range(0, 7) == 0) rb = {rb[0], {15{rb[1]}}};
            A = ra; B = rb; sub = i[0];
            @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
